// File: rtl/alu_writeback.sv
// Execute/writeback stage: evaluates the condition code against the NZCV status register,
// updates flags and retire/skip counters, and holds one register-file write entry.
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Alu_Out,
  input  logic [3:0]        Alu_Flags,
  input  logic [3:0]        Opcode,
  input  logic [3:0]        Cond,
  input  logic              S,
  input  logic [ADDR_W-1:0] Rd,
  output logic              Wb_Valid,
  input  logic              Wb_Ready,
  output logic [ADDR_W-1:0] Wb_Addr,
  output logic [DATA_W-1:0] Wb_Data,
  output logic [3:0]        Flags_Q,
  output logic [CNT_W-1:0]  Retire_Count,
  output logic [CNT_W-1:0]  Skip_Count
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;
  logic is_compare;
  logic accept;
  logic do_write;
  logic set_flags;

  assign flag_n = Flags_Q[3];
  assign flag_z = Flags_Q[2];
  assign flag_c = Flags_Q[1];
  assign flag_v = Flags_Q[0];

  // The entry may be overwritten in the same cycle it is drained, so a full
  // register does not stall the ALU while the register file keeps accepting.
  assign In_Ready = ~Wb_Valid | Wb_Ready;
  assign accept   = In_Valid & In_Ready;

  assign is_compare = (Opcode >= 4'b1000) && (Opcode <= 4'b1011);
  assign do_write   = accept & cond_pass & ~is_compare;
  assign set_flags  = accept & cond_pass & (S | is_compare);

  // Condition is judged against the flags before this instruction updates them.
  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = ~flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = ~flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = ~flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = ~flag_v;
      COND_HI: cond_pass = flag_c & ~flag_z;
      COND_LS: cond_pass = ~flag_c | flag_z;
      COND_GE: cond_pass = (flag_n == flag_v);
      COND_LT: cond_pass = (flag_n != flag_v);
      COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_pass = flag_z | (flag_n != flag_v);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // which is what lets back-to-back instructions see the previous flags cleanly.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Wb_Valid     <= 1'b0;
      Wb_Addr      <= '0;
      Wb_Data      <= '0;
      Flags_Q      <= 4'b0000;
      Retire_Count <= '0;
      Skip_Count   <= '0;
    end else begin
      if (do_write) begin
        Wb_Valid <= 1'b1;
        Wb_Addr  <= Rd;
        Wb_Data  <= Alu_Out;
      end else if (Wb_Ready) begin
        Wb_Valid <= 1'b0;
      end

      if (set_flags) begin
        Flags_Q <= Alu_Flags;
      end

      if (accept) begin
        if (cond_pass) begin
          Retire_Count <= Retire_Count + CNT_W'(1);
        end else begin
          Skip_Count <= Skip_Count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: stimulus pushes expected register writes into a
// queue; a monitor pops and compares on each write-back handshake.
module tb_alu_writeback;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;  // narrow counters so wrap-around is reachable quickly

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] C_EQ = 4'b0000, C_NE = 4'b0001, C_HI = 4'b1000;
  localparam logic [3:0] C_GE = 4'b1010, C_LT = 4'b1011, C_AL = 4'b1110, C_NV = 4'b1111;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              In_Valid;
  logic              In_Ready;
  logic [DATA_W-1:0] Alu_Out;
  logic [3:0]        Alu_Flags;
  logic [3:0]        Opcode;
  logic [3:0]        Cond;
  logic              S;
  logic [ADDR_W-1:0] Rd;
  logic              Wb_Valid;
  logic              Wb_Ready;
  logic [ADDR_W-1:0] Wb_Addr;
  logic [DATA_W-1:0] Wb_Data;
  logic [3:0]        Flags_Q;
  logic [CNT_W-1:0]  Retire_Count;
  logic [CNT_W-1:0]  Skip_Count;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  alu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Alu_Out(Alu_Out), .Alu_Flags(Alu_Flags), .Opcode(Opcode), .Cond(Cond),
    .S(S), .Rd(Rd),
    .Wb_Valid(Wb_Valid), .Wb_Ready(Wb_Ready), .Wb_Addr(Wb_Addr), .Wb_Data(Wb_Data),
    .Flags_Q(Flags_Q), .Retire_Count(Retire_Count), .Skip_Count(Skip_Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one instruction starting at a falling edge, wait for acceptance, and
  // return at the falling edge after the accepting rising edge with In_Valid still high.
  task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                       input logic [3:0] flags, input logic [DATA_W-1:0] out,
                       input logic [ADDR_W-1:0] rd, input logic exp_write);
    int budget;
    In_Valid  = 1'b1;
    Opcode    = op;
    Cond      = cond;
    S         = s;
    Alu_Flags = flags;
    Alu_Out   = out;
    Rd        = rd;
    if (exp_write) exp_q.push_back('{addr: rd, data: out});
    budget = 20;
    while (!In_Ready && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    if (!In_Ready) check("accept_timeout", 32'(In_Ready), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle();
    In_Valid = 1'b0;
    @(negedge Clk);
  endtask

  // Monitor: the handshake completes at the next rising edge.
  initial begin
    wb_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (!Rst && Wb_Valid && Wb_Ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_unexpected: got addr %0h data %0h expected no write", Wb_Addr, Wb_Data);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 32'(Wb_Addr), 32'(e.addr));
          check("wb_data", Wb_Data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; In_Valid = 1'b0; Wb_Ready = 1'b1;
    Alu_Out = '0; Alu_Flags = '0; Opcode = '0; Cond = '0; S = 1'b0; Rd = '0;
    repeat (2) @(negedge Clk);

    check("rst_wb_valid", 32'(Wb_Valid), 32'd0);
    check("rst_wb_addr", 32'(Wb_Addr), 32'd0);
    check("rst_wb_data", Wb_Data, 32'd0);
    check("rst_flags", 32'(Flags_Q), 32'd0);
    check("rst_retire", 32'(Retire_Count), 32'd0);
    check("rst_skip", 32'(Skip_Count), 32'd0);
    Rst = 1'b0;
    #1 check("rst_in_ready", 32'(In_Ready), 32'd1);
    @(negedge Clk);

    // CMP sets flags, never writes
    issue(OP_CMP, C_AL, 1'b0, 4'b1000, 32'd99, 4'd5, 1'b0);
    check("cmp_flags", 32'(Flags_Q), 32'h8);
    check("cmp_wb_valid", 32'(Wb_Valid), 32'd0);
    check("cmp_retire", 32'(Retire_Count), 32'd1);

    // ADD without S writes and leaves flags alone
    issue(OP_ADD, C_AL, 1'b0, 4'b0110, 32'd35, 4'd3, 1'b1);
    check("add_wb_valid", 32'(Wb_Valid), 32'd1);
    check("add_wb_addr", 32'(Wb_Addr), 32'd3);
    check("add_wb_data", Wb_Data, 32'd35);
    check("add_flags", 32'(Flags_Q), 32'h8);

    // Z set: EQ passes, NE skipped; drain with no new entry keeps last addr/data
    issue(OP_CMP, C_AL, 1'b0, 4'b0100, 32'd0, 4'd0, 1'b0);
    issue(OP_ADD, C_EQ, 1'b0, 4'b0000, 32'd7, 4'd1, 1'b1);
    issue(OP_ADD, C_NE, 1'b0, 4'b0000, 32'd8, 4'd2, 1'b0);
    check("ne_skip", 32'(Skip_Count), 32'd1);
    check("ne_retire", 32'(Retire_Count), 32'd4);
    check("ne_wb_valid", 32'(Wb_Valid), 32'd0);
    check("ne_wb_data_hold", Wb_Data, 32'd7);
    check("ne_wb_addr_hold", 32'(Wb_Addr), 32'd1);

    // Back-pressure: full entry with Wb_Ready low stalls the input
    Wb_Ready = 1'b0;
    issue(OP_ADD, C_AL, 1'b0, 4'b0000, 32'd50, 4'd4, 1'b1);
    In_Valid = 1'b1; Opcode = OP_ADD; Cond = C_AL; S = 1'b0; Alu_Out = 32'd60; Rd = 4'd5;
    exp_q.push_back('{addr: 4'd5, data: 32'd60});
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(In_Ready), 32'd0);
      check("stall_wb_data", Wb_Data, 32'd50);
      @(negedge Clk);
    end
    Wb_Ready = 1'b1;
    #1 check("drain_in_ready", 32'(In_Ready), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    check("drain_wb_data", Wb_Data, 32'd60);
    check("drain_wb_addr", 32'(Wb_Addr), 32'd5);
    check("drain_wb_valid", 32'(Wb_Valid), 32'd1);
    check("drain_retire", 32'(Retire_Count), 32'd6);
    idle();

    // Back-to-back: EQ must see Z from the CMP accepted the cycle before
    issue(OP_CMP, C_AL, 1'b0, 4'b0000, 32'd0, 4'd0, 1'b0);
    issue(OP_CMP, C_AL, 1'b0, 4'b0100, 32'd0, 4'd0, 1'b0);
    issue(OP_ADD, C_EQ, 1'b0, 4'b0000, 32'd77, 4'd6, 1'b1);
    check("b2b_wb_data", Wb_Data, 32'd77);
    check("b2b_flags", 32'(Flags_Q), 32'h4);
    check("b2b_retire", 32'(Retire_Count), 32'd9);

    // S=1 on ALU op; failing GE with S=1 must not touch flags; HI and LT pass on C=1,V=1
    issue(OP_ADD, C_AL, 1'b1, 4'b0011, 32'd10, 4'd7, 1'b1);
    check("s_flags", 32'(Flags_Q), 32'h3);
    issue(OP_SUB, C_GE, 1'b1, 4'b1111, 32'd11, 4'd8, 1'b0);
    check("ge_fail_flags", 32'(Flags_Q), 32'h3);
    check("ge_fail_skip", 32'(Skip_Count), 32'd2);
    issue(OP_ADD, C_HI, 1'b0, 4'b0000, 32'd12, 4'd9, 1'b1);
    issue(OP_ADD, C_LT, 1'b0, 4'b0000, 32'd13, 4'd10, 1'b1);
    check("lt_wb_data", Wb_Data, 32'd13);
    check("cond_retire", 32'(Retire_Count), 32'd12);

    // Skip counter wraps 15 -> 0
    for (int i = 0; i < 13; i++) issue(OP_ADD, C_NV, 1'b0, 4'b0000, 32'd0, 4'd0, 1'b0);
    check("skip_max", 32'(Skip_Count), 32'd15);
    issue(OP_ADD, C_NV, 1'b0, 4'b0000, 32'd0, 4'd0, 1'b0);
    check("skip_wrap", 32'(Skip_Count), 32'd0);
    idle();
    idle();

    // Reset with a pending entry and a simultaneous accept: both dropped
    Wb_Ready = 1'b0;
    issue(OP_ADD, C_AL, 1'b0, 4'b0000, 32'd90, 4'd11, 1'b1);
    In_Valid = 1'b1; Opcode = OP_ADD; Cond = C_AL; S = 1'b1; Alu_Flags = 4'b1111;
    Alu_Out = 32'd91; Rd = 4'd12;
    Wb_Ready = 1'b1;
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    exp_q.delete();
    check("rst2_wb_valid", 32'(Wb_Valid), 32'd0);
    check("rst2_wb_addr", 32'(Wb_Addr), 32'd0);
    check("rst2_wb_data", Wb_Data, 32'd0);
    check("rst2_flags", 32'(Flags_Q), 32'd0);
    check("rst2_retire", 32'(Retire_Count), 32'd0);
    check("rst2_skip", 32'(Skip_Count), 32'd0);
    Rst = 1'b0;
    In_Valid = 1'b0;
    #1 check("rst2_in_ready", 32'(In_Ready), 32'd1);
    @(negedge Clk);

    issue(OP_ADD, C_AL, 1'b0, 4'b0000, 32'd5, 4'd2, 1'b1);
    check("post_rst_retire", 32'(Retire_Count), 32'd1);
    idle();
    idle();
    idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
